// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types and constants for the four-channel round-robin mux select arbiter.
// Pulled into the arbiter top and its round-robin picker.
package mux_sel_arbiter_pkg;

    localparam int unsigned NumCh = 4;
    localparam int unsigned SelW  = 2;

    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } state_e;

    typedef logic [SelW-1:0]  sel_t;
    typedef logic [NumCh-1:0] ch_vec_t;

    function automatic ch_vec_t sel_to_onehot(input sel_t sel);
        return ch_vec_t'(1) << sel;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after the last served channel.
// Rotates the request vector so the search starts at last+1, priority-encodes, rotates back.
module mux_sel_arbiter_rr_pick
    import mux_sel_arbiter_pkg::*;
(
    input  logic [NumCh-1:0] req_i,
    input  logic [SelW-1:0]  last_i,
    output logic [SelW-1:0]  pick_o,
    output logic             valid_o
);

    logic [2*NumCh-1:0] req_dbl;
    logic [SelW:0]      start;
    logic [NumCh-1:0]   rot;
    sel_t               idx;

    assign req_dbl = {req_i, req_i};
    assign start   = {1'b0, last_i} + (SelW + 1)'(1);
    assign rot     = req_dbl[start +: NumCh];

    // Descending loop so the lowest set bit of the rotated vector wins.
    always_comb begin
        idx = '0;
        for (int i = NumCh - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = sel_t'(i);
            end
        end
    end

    assign pick_o  = idx + last_i + sel_t'(1);
    assign valid_o = |req_i;

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select pair and enable of a 4:1 enabled mux / tristate stage.
// Every grant is followed by at least one idle cycle with en low (break-before-make).
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NumCh-1:0] req_i,
    input  logic             done_i,
    output logic             s1_o,
    output logic             s0_o,
    output logic             en_o,
    output logic [NumCh-1:0] gnt_o,
    output logic             timeout_o
);

    state_e           state_q, state_d;
    sel_t             sel_q, sel_d;
    sel_t             last_q, last_d;
    ch_vec_t          gnt_q, gnt_d;
    logic             en_q, en_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    sel_t pick;
    logic pick_valid;
    logic release_req;
    logic hold_max;
    logic hold_exit;

    mux_sel_arbiter_rr_pick u_rr_pick (
        .req_i   (req_i),
        .last_i  (last_q),
        .pick_o  (pick),
        .valid_o (pick_valid)
    );

    // A consumer release takes precedence over the hold limit, so timeout only flags
    // grants that were still wanted when they were cut off.
    assign release_req = done_i | ~req_i[sel_q];
    assign hold_max    = (cnt_q == CNT_W'(MAX_HOLD));
    assign hold_exit   = release_req | hold_max;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (pick_valid) state_d = StHold;
            StHold: if (hold_exit)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sel_d     = sel_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        en_d      = en_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    sel_d  = pick;
                    last_d = pick;
                    gnt_d  = sel_to_onehot(pick);
                    en_d   = 1'b1;
                    cnt_d  = CNT_W'(1);
                end else begin
                    gnt_d = '0;
                    en_d  = 1'b0;
                end
            end
            StHold: begin
                if (hold_exit) begin
                    // Select is left as is so the mux inputs stay quiet during the gap.
                    gnt_d     = '0;
                    en_d      = 1'b0;
                    cnt_d     = '0;
                    timeout_d = hold_max & ~release_req;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                gnt_d = '0;
                en_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q     <= '0;
            last_q    <= sel_t'(NumCh - 1);
            gnt_q     <= '0;
            en_q      <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sel_q     <= sel_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            en_q      <= en_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign s1_o      = sel_q[1];
    assign s0_o      = sel_q[0];
    assign en_o      = en_q;
    assign gnt_o     = gnt_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: directed vector table, hand sequences for timeout, release and
// asynchronous reset, then random traffic against a behavioural model.
module tb_mux_sel_arbiter;

    localparam int unsigned MaxHold = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic       s1, s0, en, to;
    logic [3:0] gnt;

    int n_checks = 0;
    int n_fail   = 0;

    mux_sel_arbiter #(
        .MAX_HOLD (MaxHold),
        .CNT_W    (8)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .done_i    (done),
        .s1_o      (s1),
        .s0_o      (s0),
        .en_o      (en),
        .gnt_o     (gnt),
        .timeout_o (to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[21];

    function automatic logic [7:0] pk(input int sel, input bit e, input logic [3:0] g,
                                      input bit t);
        return {2'(sel), e, g, t};
    endfunction

    function automatic vec_t mk(input logic [3:0] r, input bit d, input int sel, input bit e,
                                input logic [3:0] g, input bit t);
        vec_t v;
        v.req  = r;
        v.done = d;
        v.exp  = pk(sel, e, g, t);
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = {s1, s0, en, gnt, to};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got sel=%0d en=%b gnt=%b to=%b, expected sel=%0d en=%b gnt=%b to=%b",
                     name, $time, act[7:6], act[5], act[4:1], act[0],
                     exp[7:6], exp[5], exp[4:1], exp[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: grant, hold length and pointer tracked as plain integers.
    bit m_granted;
    int m_sel, m_last, m_held;
    bit m_to;

    task automatic model_reset();
        m_granted = 0;
        m_sel     = 0;
        m_last    = 3;
        m_held    = 0;
        m_to      = 0;
    endtask

    task automatic model_edge(input logic [3:0] r, input bit d);
        bit released, expired;
        m_to = 0;
        if (!m_granted) begin
            for (int k = 1; k <= 4; k++) begin
                if (r[(m_last + k) % 4]) begin
                    m_sel     = (m_last + k) % 4;
                    m_last    = m_sel;
                    m_granted = 1;
                    m_held    = 1;
                    break;
                end
            end
        end else begin
            released = d || !r[m_sel];
            expired  = (m_held == MaxHold);
            if (released || expired) begin
                m_granted = 0;
                m_to      = expired && !released;
            end else begin
                m_held++;
            end
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [3:0] g;
        g = m_granted ? 4'(1 << m_sel) : 4'b0000;
        return pk(m_sel, m_granted, g, m_to);
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Round-robin with done every third cycle, then single requester, then idle.
        tbl[0]  = mk(4'hF, 0, 0, 1, 4'b0001, 0);
        tbl[1]  = mk(4'hF, 0, 0, 1, 4'b0001, 0);
        tbl[2]  = mk(4'hF, 1, 0, 0, 4'b0000, 0);
        tbl[3]  = mk(4'hF, 0, 1, 1, 4'b0010, 0);
        tbl[4]  = mk(4'hF, 0, 1, 1, 4'b0010, 0);
        tbl[5]  = mk(4'hF, 1, 1, 0, 4'b0000, 0);
        tbl[6]  = mk(4'hF, 0, 2, 1, 4'b0100, 0);
        tbl[7]  = mk(4'hF, 0, 2, 1, 4'b0100, 0);
        tbl[8]  = mk(4'hF, 1, 2, 0, 4'b0000, 0);
        tbl[9]  = mk(4'hF, 0, 3, 1, 4'b1000, 0);
        tbl[10] = mk(4'hF, 0, 3, 1, 4'b1000, 0);
        tbl[11] = mk(4'hF, 1, 3, 0, 4'b0000, 0);
        tbl[12] = mk(4'hF, 0, 0, 1, 4'b0001, 0);
        tbl[13] = mk(4'h4, 0, 0, 0, 4'b0000, 0);
        tbl[14] = mk(4'h4, 0, 2, 1, 4'b0100, 0);
        tbl[15] = mk(4'h4, 0, 2, 1, 4'b0100, 0);
        tbl[16] = mk(4'h4, 1, 2, 0, 4'b0000, 0);
        tbl[17] = mk(4'h4, 0, 2, 1, 4'b0100, 0);
        tbl[18] = mk(4'h0, 0, 2, 0, 4'b0000, 0);
        tbl[19] = mk(4'h0, 0, 2, 0, 4'b0000, 0);
        tbl[20] = mk(4'h0, 1, 2, 0, 4'b0000, 0);

        // Reset held with all requests up.
        rst_n = 1'b0;
        req   = 4'hF;
        done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", pk(0, 0, 4'b0000, 0));
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            req  = tbl[i].req;
            done = tbl[i].done;
            step();
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Hold limit: sole requester ch3, no done.
        req  = 4'b1000;
        done = 1'b0;
        for (int i = 1; i <= MaxHold; i++) begin
            step();
            check($sformatf("hold_c%0d", i), pk(3, 1, 4'b1000, 0));
        end
        step();
        check("timeout_exit", pk(3, 0, 4'b0000, 1));
        step();
        check("timeout_regrant", pk(3, 1, 4'b1000, 0));

        // Request drop on ch1 while ch3 waits.
        req  = 4'b1010;
        done = 1'b1;
        step();
        check("done_release", pk(3, 0, 4'b0000, 0));
        done = 1'b0;
        step();
        check("grant_ch1", pk(1, 1, 4'b0010, 0));
        step();
        check("hold_ch1", pk(1, 1, 4'b0010, 0));
        req = 4'b1000;
        step();
        check("drop_release", pk(1, 0, 4'b0000, 0));
        step();
        check("grant_ch3", pk(3, 1, 4'b1000, 0));

        // Asynchronous reset mid-grant, observed before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", pk(0, 0, 4'b0000, 0));
        req = 4'hF;
        step();
        check("reset_held", pk(0, 0, 4'b0000, 0));
        rst_n = 1'b1;
        step();
        check("post_reset_ch0", pk(0, 1, 4'b0001, 0));

        // Random traffic against the model.
        apply_reset();
        model_reset();
        req  = 4'h0;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 5) == 0);
            @(posedge clk);
            model_edge(req, done);
            #1;
            check($sformatf("rand%0d", i), model_out());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
